stage_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RISC-V core. Drives the 2-bit `stage` code consumed by the decoder, fetches instructions through a ready/valid memory handshake, and holds the registered instruction word. Starts and waits on the execute unit, gates register-file write enables to a single write-back cycle, and owns the program counter, including branch and jump redirection. Sits between instruction memory, the decoder and the ALU/FPU execute block.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_unit.sv | 28 ++
 rtl/stage_sequencer.sv | 131 +++++++++++++
 tb/tb_stage_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencer state encoding, decoder stage codes and opcodes.
package cpu_pkg;

  localparam int unsigned STAGE_W = 2;

  localparam logic [STAGE_W-1:0] STAGE_FETCH     = 2'b00;
  localparam logic [STAGE_W-1:0] STAGE_DECODE    = 2'b01;
  localparam logic [STAGE_W-1:0] STAGE_EXECUTE   = 2'b10;
  localparam logic [STAGE_W-1:0] STAGE_WRITEBACK = 2'b11;

  // Low two bits of the active states match the decoder stage code.
  typedef enum logic [2:0] {
    ST_FETCH     = {1'b0, STAGE_FETCH},
    ST_DECODE    = {1'b0, STAGE_DECODE},
    ST_EXECUTE   = {1'b0, STAGE_EXECUTE},
    ST_WRITEBACK = {1'b0, STAGE_WRITEBACK},
    ST_HALT      = 3'b100
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FP     = 7'b1010011;

endpackage

// File: rtl/pc_unit.sv
// Program counter register: sequential or redirected update, word aligned.
module pc_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            update,
  input  logic            take,
  input  logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] sum;

  assign offset = take ? immediate : XLEN'(4);
  assign sum    = pc + offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (update) begin
      pc <= {sum[XLEN-1:2], 2'b00};
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with PC ownership
// and single-cycle register-file write gating.
module stage_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction,
  output logic [1:0]      stage,
  input  logic            branch_instruction,
  input  logic            jump_instruction,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] immediate,
  output logic            exec_start,
  input  logic            exec_done,
  input  logic            irf_we_req,
  input  logic            frf_we_req,
  output logic            irf_write_enable,
  output logic            frf_write_enable,
  input  logic            halt_req,
  output logic            halted,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     retired_count
);

  state_t state;
  state_t next_state;
  logic   take;
  logic   in_writeback;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state       = state;
    imem_req         = 1'b0;
    halted           = 1'b0;
    stage            = STAGE_FETCH;
    in_writeback     = 1'b0;
    irf_write_enable = 1'b0;
    frf_write_enable = 1'b0;
    unique case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        stage      = STAGE_DECODE;
        next_state = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        stage = STAGE_EXECUTE;
        if (exec_done) next_state = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        stage            = STAGE_WRITEBACK;
        in_writeback     = 1'b1;
        irf_write_enable = irf_we_req;
        frf_write_enable = frf_we_req;
        next_state       = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        next_state = ST_FETCH;
      end
    endcase
  end

  // DECODE always hands off to EXECUTE, so this is high for its first cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_start <= 1'b0;
    end else begin
      exec_start <= (state == ST_DECODE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
    end else if (state == ST_FETCH && imem_ready) begin
      instruction <= imem_rdata;
    end
  end

  // Redirect decision is captured with the execute result, used in WRITEBACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take <= 1'b0;
    end else if (state == ST_EXECUTE && exec_done) begin
      take <= jump_instruction | (branch_instruction & branch_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (in_writeback) begin
      retired_count <= retired_count + 32'd1;
    end
  end

  pc_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk       (clk),
    .rst_n     (rst_n),
    .update    (in_writeback),
    .take      (take),
    .immediate (immediate),
    .pc        (pc)
  );

  assign imem_addr = pc;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: per-scenario tasks drive instructions,
// push expected retire results, and compare when the instruction retires.
module tb_stage_sequencer;
  import cpu_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [1:0]  stage;
  logic        branch_instruction;
  logic        jump_instruction;
  logic        branch_taken;
  logic [31:0] immediate;
  logic        exec_start;
  logic        exec_done;
  logic        irf_we_req;
  logic        frf_we_req;
  logic        irf_write_enable;
  logic        frf_write_enable;
  logic        halt_req;
  logic        halted;
  logic [31:0] pc;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  stage_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ready         (imem_ready),
    .imem_rdata         (imem_rdata),
    .instruction        (instruction),
    .stage              (stage),
    .branch_instruction (branch_instruction),
    .jump_instruction   (jump_instruction),
    .branch_taken       (branch_taken),
    .immediate          (immediate),
    .exec_start         (exec_start),
    .exec_done          (exec_done),
    .irf_we_req         (irf_we_req),
    .frf_we_req         (frf_we_req),
    .irf_write_enable   (irf_write_enable),
    .frf_write_enable   (frf_write_enable),
    .halt_req           (halt_req),
    .halted             (halted),
    .pc                 (pc),
    .retired_count      (retired_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] count;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic [31:0] m_instr;

  logic [31:0] trace_word;
  int          trace_len;
  int          n_req, n_start, n_irf, n_frf, n_we_bad;
  logic [31:0] instr_before_ready;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic tk,
                                             input logic [31:0] imm);
    logic [31:0] n;
    n = tk ? cur + imm : cur + 32'd4;
    return {n[31:2], 2'b00};
  endfunction

  task automatic expect_instr(input logic [31:0] rdata, input logic tk, input logic [31:0] imm);
    exp_t e;
    m_pc    = model_next(m_pc, tk, imm);
    m_count = m_count + 32'd1;
    m_instr = rdata;
    e.pc    = m_pc;
    e.count = m_count;
    e.instr = rdata;
    sb.push_back(e);
  endtask

  task automatic log_cycle();
    trace_word = {trace_word[29:0], stage};
    trace_len++;
    if (imem_req) n_req++;
    if (exec_start) n_start++;
    if (irf_write_enable) begin
      n_irf++;
      if (stage !== 2'b11) n_we_bad++;
    end
    if (frf_write_enable) begin
      n_frf++;
      if (stage !== 2'b11) n_we_bad++;
    end
  endtask

  // Drive one instruction from FETCH through WRITEBACK; irrelevant strobes are
  // asserted in the stages where they must be ignored.
  task automatic do_instr(input logic [31:0] rdata, input int r, input int d,
                          input logic br, input logic jmp, input logic tk,
                          input logic [31:0] imm, input logic irf, input logic frf,
                          input logic hlt);
    trace_word = '0; trace_len = 0;
    n_req = 0; n_start = 0; n_irf = 0; n_frf = 0; n_we_bad = 0;
    branch_instruction = br; jump_instruction = jmp; immediate = imm;
    irf_we_req = irf; frf_we_req = frf;
    halt_req = 1'b0; exec_done = 1'b1; branch_taken = ~tk;
    for (int i = 0; i <= r; i++) begin
      imem_ready = (i == r);
      imem_rdata = (i == r) ? rdata : ~rdata;
      if (i == r) instr_before_ready = instruction;
      log_cycle();
      @(negedge clk);
    end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; halt_req = 1'b1;
    log_cycle();
    @(negedge clk);
    for (int j = 0; j <= d; j++) begin
      exec_done    = (j == d);
      branch_taken = (j == d) ? tk : ~tk;
      log_cycle();
      @(negedge clk);
    end
    exec_done = 1'b1; halt_req = hlt; branch_taken = ~tk;
    log_cycle();
    @(negedge clk);
    imem_ready = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
    irf_we_req = 1'b0; frf_we_req = 1'b0;
    branch_instruction = 1'b0; jump_instruction = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0; branch_instruction = 1'b0; jump_instruction = 1'b0;
    branch_taken = 1'b0; immediate = '0; exec_done = 1'b0; halt_req = 1'b0;
    irf_we_req = 1'b1; frf_we_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== RESET_PC || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_pc: got pc=%h addr=%h want %h", pc, imem_addr, RESET_PC);
    end
    checks++;
    if (instruction !== 32'h0 || retired_count !== 32'h0) begin
      errors++; $display("FAIL reset_regs: got instr=%h count=%0d want 0/0", instruction, retired_count);
    end
    checks++;
    if (stage !== 2'b00 || imem_req !== 1'b1 || halted !== 1'b0 || exec_start !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got stage=%b req=%b halted=%b start=%b want 00/1/0/0",
                         stage, imem_req, halted, exec_start);
    end
    checks++;
    if (irf_write_enable !== 1'b0 || frf_write_enable !== 1'b0) begin
      errors++; $display("FAIL reset_we: got irf=%b frf=%b want 0/0", irf_write_enable, frf_write_enable);
    end
    irf_we_req = 1'b0; frf_we_req = 1'b0;
    m_pc = RESET_PC; m_count = '0; m_instr = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_straight_line();
    exp_t e;
    logic [31:0] rd;
    for (int k = 0; k < 3; k++) begin
      rd = {25'(k + 1), OP_FP};
      expect_instr(rd, 1'b0, 32'h0);
      do_instr(rd, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (trace_len != 4 || trace_word[7:0] !== 8'h1B) begin
        errors++; $display("FAIL straight_stages[%0d]: got len=%0d seq=%h want 4/1b", k, trace_len, trace_word[7:0]);
      end
      checks++;
      if (pc !== e.pc || retired_count !== e.count || instruction !== e.instr) begin
        errors++; $display("FAIL straight_retire[%0d]: got pc=%h cnt=%0d ins=%h want %h/%0d/%h",
                           k, pc, retired_count, instruction, e.pc, e.count, e.instr);
      end
      checks++;
      if (n_start != 1 || n_req != 1 || imem_req !== 1'b1 || stage !== 2'b00) begin
        errors++; $display("FAIL straight_handshake[%0d]: got start=%0d req=%0d req_now=%b stage=%b want 1/1/1/00",
                           k, n_start, n_req, imem_req, stage);
      end
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    logic [31:0] prev;
    prev = m_instr;
    expect_instr(32'h00A0_0093, 1'b0, 32'h0);
    do_instr(32'h00A0_0093, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (n_req != 4 || trace_len != 7 || trace_word[13:0] !== 14'h001B) begin
      errors++; $display("FAIL memwait_stall: got req=%0d len=%0d seq=%h want 4/7/001b", n_req, trace_len, trace_word[13:0]);
    end
    checks++;
    if (instr_before_ready !== prev) begin
      errors++; $display("FAIL memwait_early_load: got %h want %h", instr_before_ready, prev);
    end
    checks++;
    if (pc !== e.pc || retired_count !== e.count || instruction !== e.instr) begin
      errors++; $display("FAIL memwait_retire: got pc=%h cnt=%0d ins=%h want %h/%0d/%h",
                         pc, retired_count, instruction, e.pc, e.count, e.instr);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    logic        br_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        jmp_t [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tk_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] imm_t [6] = '{32'h0, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFF0, 32'h7, 32'h40};
    logic [31:0] imm;
    logic [31:0] want_t [6] = '{32'h100, 32'h0F0, 32'h100, 32'h104, 32'h108, 32'h10C};
    for (int k = 0; k < 6; k++) begin
      imm = (k == 0) ? 32'h100 - m_pc : imm_t[k];
      expect_instr({25'(k), br_t[k] ? OP_BRANCH : OP_JAL}, jmp_t[k] | (br_t[k] & tk_t[k]), imm);
      do_instr({25'(k), br_t[k] ? OP_BRANCH : OP_JAL}, k % 2, k % 3,
               br_t[k], jmp_t[k], tk_t[k], imm, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc !== want_t[k] || retired_count !== e.count) begin
        errors++; $display("FAIL branch_pc[%0d]: got pc=%h cnt=%0d want %h/%0d", k, pc, retired_count, want_t[k], e.count);
      end
    end
  endtask

  task automatic test_write_gating();
    exp_t e;
    expect_instr(32'h0011_0113, 1'b0, 32'h0);
    do_instr(32'h0011_0113, 0, 5, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (n_irf != 1 || n_frf != 0 || n_we_bad != 0 || trace_len != 9 || n_start != 1) begin
      errors++; $display("FAIL gating_irf: got irf=%0d frf=%0d bad=%0d len=%0d start=%0d want 1/0/0/9/1",
                         n_irf, n_frf, n_we_bad, trace_len, n_start);
    end
    checks++;
    if (pc !== e.pc || retired_count !== e.count) begin
      errors++; $display("FAIL gating_retire: got pc=%h cnt=%0d want %h/%0d", pc, retired_count, e.pc, e.count);
    end
    expect_instr({25'h3, OP_FP}, 1'b0, 32'h0);
    do_instr({25'h3, OP_FP}, 1, 2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if (n_frf != 1 || n_irf != 0 || n_we_bad != 0 || pc !== e.pc) begin
      errors++; $display("FAIL gating_frf: got frf=%0d irf=%0d bad=%0d pc=%h want 1/0/0/%h",
                         n_frf, n_irf, n_we_bad, pc, e.pc);
    end
  endtask

  task automatic test_reset_mid_execute();
    int we_seen;
    we_seen = 0;
    irf_we_req = 1'b1; frf_we_req = 1'b1; exec_done = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (stage !== 2'b10 || exec_start !== 1'b0 || pc === RESET_PC) begin
      errors++; $display("FAIL midexec_setup: got stage=%b start=%b pc=%h want 10/0/non-reset", stage, exec_start, pc);
    end
    #2 rst_n = 1'b0;
    #1;
    if (irf_write_enable || frf_write_enable) we_seen++;
    checks++;
    if (pc !== RESET_PC || retired_count !== 32'h0 || instruction !== 32'h0 || stage !== 2'b00) begin
      errors++; $display("FAIL midexec_reset: got pc=%h cnt=%0d ins=%h stage=%b want %h/0/0/00",
                         pc, retired_count, instruction, stage, RESET_PC);
    end
    exec_done = 1'b1;
    @(negedge clk);
    if (irf_write_enable || frf_write_enable) we_seen++;
    exec_done = 1'b0; irf_we_req = 1'b0; frf_we_req = 1'b0;
    rst_n = 1'b1;
    checks++;
    if (we_seen != 0 || retired_count !== 32'h0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL midexec_we: got we_pulses=%0d cnt=%0d req=%b want 0/0/1", we_seen, retired_count, imem_req);
    end
    m_pc = RESET_PC; m_count = '0; m_instr = '0;
  endtask

  task automatic test_halt_wrap();
    exp_t e;
    int   reqs;
    expect_instr({25'h1, OP_JAL}, 1'b1, 32'hFFFF_FFFC);
    do_instr({25'h1, OP_JAL}, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pc !== 32'hFFFF_FFFC || pc !== e.pc || retired_count !== e.count) begin
      errors++; $display("FAIL halt_setup_pc: got pc=%h cnt=%0d want fffffffc/%0d", pc, retired_count, e.count);
    end
    expect_instr(32'h0000_0013, 1'b0, 32'h0);
    do_instr(32'h0000_0013, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (pc !== 32'h0 || pc !== e.pc || halted !== 1'b1 || stage !== 2'b00 || retired_count !== e.count) begin
      errors++; $display("FAIL halt_wrap: got pc=%h halted=%b stage=%b cnt=%0d want 0/1/00/%0d",
                         pc, halted, stage, retired_count, e.count);
    end
    reqs = 0;
    imem_ready = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req || exec_start || !halted) reqs++;
    end
    imem_ready = 1'b0; exec_done = 1'b0;
    checks++;
    if (reqs != 0 || retired_count !== e.count || pc !== 32'h0) begin
      errors++; $display("FAIL halt_parked: got active_cycles=%0d cnt=%0d pc=%h want 0/%0d/0", reqs, retired_count, pc, e.count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || retired_count !== 32'h0) begin
      errors++; $display("FAIL halt_exit_reset: got halted=%b req=%b cnt=%0d want 0/1/0", halted, imem_req, retired_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_mem_wait();
    test_branch();
    test_write_gating();
    test_reset_mid_execute();
    test_halt_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
